// File: rtl/roulette_spin_animator.sv
// roulette_spin_animator
//
// Turns a winning pocket number into a visible wheel spin for the roulette
// LED decoder. A start request sweeps the lit pocket around the wheel at a
// fixed fast rate for MIN_LAPS wraps through pocket 0. It then slows by
// DECEL_INC cycles per step, saturating at MAX_DIV, and stops exactly on the
// latched target.
//
// Optional feature macro: SPIN_CLICK_EN
//   Defined   : adds the click output, a buzzer pulse of CLICK_LEN cycles on
//               every step. The pulse is cut short and restarted by the next
//               step.
//   Undefined : no click port and no click counter.
//
// Ports:
//   clock    in   1  system clock, rising-edge active
//   reset    in   1  asynchronous active-low reset
//   start    in   1  spin request, sampled every edge (ignored while busy)
//   target   in   6  winning pocket, latched when start is accepted
//   pos_out  out  6  currently lit pocket, to the LED decoder
//   busy     out  1  high while a spin is in progress
//   done     out  1  one-cycle pulse on the landing edge
//   err      out  1  one-cycle pulse when start carries an invalid target
//   click    out  1  step click (SPIN_CLICK_EN only)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no spin; pos_out holds the last landed pocket
// S_FAST | constant-rate sweep, counting wraps through pocket 0
// S_SLOW | decelerating; lands on the step that reaches the target

module roulette_spin_animator #(
    parameter int NUM_POCKETS = 38,
    parameter int BASE_DIV    = 1250000,
    parameter int DECEL_INC   = 312500,
    parameter int MAX_DIV     = 12500000,
    parameter int MIN_LAPS    = 3,
    parameter int CLICK_LEN   = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] target,
    output logic [5:0] pos_out,
    output logic       busy,
    output logic       done,
    output logic       err
`ifdef SPIN_CLICK_EN
    ,
    output logic       click
`endif
);

    // The interval register is wide enough for MAX_DIV + DECEL_INC, so the
    // saturation compare never sees a wrapped sum.
    localparam int DIV_W = $clog2(MAX_DIV + DECEL_INC + 1);
    localparam int LAP_W = (MIN_LAPS < 2) ? 1 : $clog2(MIN_LAPS + 1);

    localparam logic [DIV_W-1:0] BASE_V   = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] INC_V    = DIV_W'(DECEL_INC);
    localparam logic [DIV_W-1:0] MAX_V    = DIV_W'(MAX_DIV);
    localparam logic [LAP_W-1:0] LAST_LAP = LAP_W'(MIN_LAPS - 1);
    localparam logic [5:0]       LAST_POS = 6'(NUM_POCKETS - 1);
    localparam logic [6:0]       POS_LIM  = 7'(NUM_POCKETS);

    if (MIN_LAPS < 1 || CLICK_LEN < 1 || NUM_POCKETS < 2 || NUM_POCKETS > 64
        || BASE_DIV < 1) begin : g_bad_param
        $error("roulette_spin_animator: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FAST = 2'd1,
        S_SLOW = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] tick_cnt, tick_nxt;
    logic [DIV_W-1:0] div_reg, div_nxt;
    logic [LAP_W-1:0] laps, laps_nxt;
    logic [5:0]       tgt_reg, tgt_nxt;
    logic [5:0]       pos_nxt;
    logic             busy_nxt, done_nxt, err_nxt;

    logic             step;
    logic [5:0]       pos_step;
    logic [DIV_W-1:0] div_sum, div_sat;

    assign step     = (state != S_IDLE) && (tick_cnt == div_reg - DIV_W'(1));
    assign pos_step = (pos_out == LAST_POS) ? 6'd0 : pos_out + 6'd1;
    assign div_sum  = div_reg + INC_V;
    assign div_sat  = (div_sum > MAX_V) ? MAX_V : div_sum;

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        div_nxt   = div_reg;
        laps_nxt  = laps;
        tgt_nxt   = tgt_reg;
        pos_nxt   = pos_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if ({1'b0, target} < POS_LIM) begin
                        tgt_nxt   = target;
                        div_nxt   = BASE_V;
                        tick_nxt  = '0;
                        laps_nxt  = '0;
                        busy_nxt  = 1'b1;
                        state_nxt = S_FAST;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            S_FAST: begin
                if (step) begin
                    tick_nxt = '0;
                    pos_nxt  = pos_step;
                    if (pos_out == LAST_POS) begin
                        laps_nxt = laps + LAP_W'(1);
                        if (laps == LAST_LAP) begin
                            // Target 0 is reached by this very wrap, so the
                            // spin lands without ever slowing down.
                            if (tgt_reg == 6'd0) begin
                                state_nxt = S_IDLE;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = S_SLOW;
                                div_nxt   = div_sat;
                            end
                        end
                    end
                end else begin
                    tick_nxt = tick_cnt + DIV_W'(1);
                end
            end

            S_SLOW: begin
                if (step) begin
                    tick_nxt = '0;
                    pos_nxt  = pos_step;
                    div_nxt  = div_sat;
                    if (pos_step == tgt_reg) begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    tick_nxt = tick_cnt + DIV_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            div_reg  <= BASE_V;
            laps     <= '0;
            tgt_reg  <= '0;
            pos_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            div_reg  <= div_nxt;
            laps     <= laps_nxt;
            tgt_reg  <= tgt_nxt;
            pos_out  <= pos_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

`ifdef SPIN_CLICK_EN
    localparam int CK_W = (CLICK_LEN < 2) ? 1 : $clog2(CLICK_LEN);

    logic [CK_W-1:0] click_cnt;

    // Down-counter holds the cycles of pulse left after the current one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            click     <= 1'b0;
            click_cnt <= '0;
        end else if (step) begin
            click     <= 1'b1;
            click_cnt <= CK_W'(CLICK_LEN - 1);
        end else if (click) begin
            if (click_cnt == '0) begin
                click <= 1'b0;
            end else begin
                click_cnt <= click_cnt - CK_W'(1);
            end
        end
    end
`endif

endmodule
